// File: rtl/vend_pkg.sv
// Shared vending definitions: change codes and the dispenser state encoding.
package vend_pkg;

    // Change codes, as produced by the vending FSM
    localparam logic [2:0] CHG_0  = 3'b000;
    localparam logic [2:0] CHG_5  = 3'b001;
    localparam logic [2:0] CHG_10 = 3'b010;
    localparam logic [2:0] CHG_15 = 3'b011;
    localparam logic [2:0] CHG_20 = 3'b100;

    typedef enum logic [2:0] {
        StIdle,
        StSoda,
        StSodaGap,
        StDime,
        StDimeGap,
        StNickel,
        StNickelGap,
        StDone
    } disp_state_e;

    // Codes above 20c have no meaning and are dispensed as zero change
    function automatic logic code_valid(input logic [2:0] code);
        return code <= CHG_20;
    endfunction

endpackage

// File: rtl/dispense_timer.sv
// Loadable down-counter that stops at 1 and flags the final cycle of a timed state.
module dispense_timer #(
    parameter int unsigned Width = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    output logic             last
);

    logic [Width-1:0] count_q;

    // Load on state entry, otherwise count down and hold at 1 so it never wraps
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q > Width'(1)) begin
            count_q <= count_q - Width'(1);
        end
    end

    assign last = (count_q <= Width'(1));

endmodule

// File: rtl/change_dispenser.sv
// Drives the soda motor and coin ejectors for each vend event, with one pending slot.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       soda_i,
    input  logic [2:0] change_i,
    output logic       soda_motor_o,
    output logic       dime_eject_o,
    output logic       nickel_eject_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       fault_o
);

    localparam int unsigned MaxCycles = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int unsigned TimerW    = $clog2(MaxCycles + 1);

    disp_state_e       state_q, state_d;
    logic [1:0]        act_dimes_q;
    logic              act_nickel_q;
    logic              pend_valid_q;
    logic [2:0]        pend_code_q;
    logic              fault_q;

    logic [2:0]        event_code;
    logic              event_bad;
    logic              timer_load;
    logic [TimerW-1:0] timer_val;
    logic              timer_last;

    assign event_code = code_valid(change_i) ? change_i : CHG_0;
    assign event_bad  = soda_i && !code_valid(change_i);

    // Next-state selection; timed states exit on the timer's last cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (soda_i) state_d = StSoda;
            end
            StSoda: begin
                if (timer_last) state_d = StSodaGap;
            end
            StSodaGap: begin
                if (timer_last) begin
                    if (act_dimes_q != 2'd0)  state_d = StDime;
                    else if (act_nickel_q)    state_d = StNickel;
                    else                      state_d = StDone;
                end
            end
            StDime: begin
                if (timer_last) state_d = StDimeGap;
            end
            StDimeGap: begin
                // Count is decremented on this exit, so 1 means the last dime
                if (timer_last) begin
                    if (act_dimes_q != 2'd1)  state_d = StDime;
                    else if (act_nickel_q)    state_d = StNickel;
                    else                      state_d = StDone;
                end
            end
            StNickel: begin
                if (timer_last) state_d = StNickelGap;
            end
            StNickelGap: begin
                if (timer_last) state_d = StDone;
            end
            StDone: begin
                state_d = (pend_valid_q || soda_i) ? StSoda : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Every timed state is entered from a different state, so a change means entry
    always_comb begin
        timer_load = (state_d != state_q);
        case (state_d)
            StSodaGap, StDimeGap, StNickelGap: timer_val = TimerW'(GAP_CYCLES);
            default:                           timer_val = TimerW'(PULSE_CYCLES);
        endcase
    end

    dispense_timer #(
        .Width (TimerW)
    ) u_timer (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .load     (timer_load),
        .load_val (timer_val),
        .last     (timer_last)
    );

    // State, active vend, pending slot and fault pulse
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            act_dimes_q  <= 2'd0;
            act_nickel_q <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_code_q  <= CHG_0;
            fault_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= 1'b0;
            if (state_q == StIdle) begin
                if (soda_i) begin
                    act_dimes_q  <= event_code[2:1];
                    act_nickel_q <= event_code[0];
                    fault_q      <= event_bad;
                end
            end else if (state_q == StDone) begin
                if (pend_valid_q) begin
                    // Promote pending; a same-cycle event refills the freed slot
                    act_dimes_q  <= pend_code_q[2:1];
                    act_nickel_q <= pend_code_q[0];
                    pend_valid_q <= soda_i;
                    if (soda_i) pend_code_q <= event_code;
                    fault_q      <= event_bad;
                end else if (soda_i) begin
                    act_dimes_q  <= event_code[2:1];
                    act_nickel_q <= event_code[0];
                    fault_q      <= event_bad;
                end
            end else begin
                if (soda_i) begin
                    if (!pend_valid_q) begin
                        pend_valid_q <= 1'b1;
                        pend_code_q  <= event_code;
                        fault_q      <= event_bad;
                    end else begin
                        fault_q      <= 1'b1;
                    end
                end
                if (state_q == StDimeGap && timer_last) begin
                    act_dimes_q <= act_dimes_q - 2'd1;
                end
            end
        end
    end

    assign soda_motor_o   = (state_q == StSoda);
    assign dime_eject_o   = (state_q == StDime);
    assign nickel_eject_o = (state_q == StNickel);
    assign busy_o         = (state_q != StIdle);
    assign done_o         = (state_q == StDone);
    assign fault_o        = fault_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus random traffic against a timeline model.
module tb_change_dispenser;

    localparam int P = 4;
    localparam int G = 2;
    localparam int T = P + G;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       soda_i = 1'b0;
    logic [2:0] change_i = 3'b000;
    logic       soda_motor_o, dime_eject_o, nickel_eject_o, busy_o, done_o, fault_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: each vend is a run of slots of T cycles (soda, dimes, nickels) then a done cycle
    logic       m_act = 1'b0;
    int         m_s = 0, m_d = 0, m_n = 0, m_done = 0;
    logic       m_pend_v = 1'b0;
    logic [2:0] m_pend_code = 3'b000;
    logic       m_fault = 1'b0;

    change_dispenser #(
        .PULSE_CYCLES (P),
        .GAP_CYCLES   (G)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .soda_i         (soda_i),
        .change_i       (change_i),
        .soda_motor_o   (soda_motor_o),
        .dime_eject_o   (dime_eject_o),
        .nickel_eject_o (nickel_eject_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .fault_o        (fault_o)
    );

    always #5 clk = ~clk;

    // Expected {soda, dime, nickel, busy, done, fault} in cycle c
    function automatic logic [5:0] model_out(input int c);
        logic soda, dime, nick, busy, done;
        int   o, slot, w;
        soda = 1'b0; dime = 1'b0; nick = 1'b0; busy = 1'b0; done = 1'b0;
        if (m_act) begin
            o    = c - m_s;
            slot = o / T;
            w    = o % T;
            busy = 1'b1;
            done = (c == m_done);
            if (!done && w < P) begin
                soda = (slot == 0);
                dime = (slot >= 1) && (slot <= m_d);
                nick = (slot > m_d) && (slot <= m_d + m_n);
            end
        end
        return {soda, dime, nick, busy, done, m_fault};
    endfunction

    task automatic start_vend(input int c, input logic [2:0] code);
        m_act  = 1'b1;
        m_s    = c + 1;
        m_d    = int'(code) / 2;
        m_n    = int'(code) % 2;
        m_done = m_s + (1 + m_d + m_n) * T;
    endtask

    task automatic model_update(input logic rst, input logic ev, input logic [2:0] code);
        logic       valid, f;
        logic [2:0] eff;
        valid = (code <= 3'd4);
        eff   = valid ? code : 3'd0;
        f     = 1'b0;
        if (!rst) begin
            m_act    = 1'b0;
            m_pend_v = 1'b0;
        end else if (!m_act) begin
            if (ev) begin
                start_vend(cyc, eff);
                f = !valid;
            end
        end else if (cyc == m_done) begin
            if (m_pend_v) begin
                start_vend(cyc, m_pend_code);
                m_pend_v    = ev;
                m_pend_code = eff;
                f           = ev && !valid;
            end else if (ev) begin
                start_vend(cyc, eff);
                f = !valid;
            end else begin
                m_act = 1'b0;
            end
        end else if (ev) begin
            if (!m_pend_v) begin
                m_pend_v    = 1'b1;
                m_pend_code = eff;
                f           = !valid;
            end else begin
                f = 1'b1;
            end
        end
        m_fault = f;
    endtask

    // One cycle: sample outputs of the current cycle, then drive inputs for it
    task automatic step(input logic rst, input logic ev, input logic [2:0] code,
                        output logic [5:0] obs, output logic [5:0] exp);
        @(negedge clk);
        obs = {soda_motor_o, dime_eject_o, nickel_eject_o, busy_o, done_o, fault_o};
        exp = model_out(cyc);
        rst_ni   = rst;
        soda_i   = ev;
        change_i = code;
        model_update(rst, ev, code);
        cyc++;
    endtask

    task automatic test_reset;
        logic [5:0] obs, exp;
        for (int i = 0; i < 8; i++) begin
            step(i >= 2, 1'b0, 3'b000, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset cycle %0d: outputs %b, required %b", i, obs, exp);
            end
            checks++;
            if (obs !== 6'b000000) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: outputs %b, required 000000", i, obs);
            end
        end
    endtask

    task automatic test_single_vend;
        logic [5:0] obs, exp;
        int dime_cyc = 0, nick_cyc = 0, done_at = -1;
        for (int i = 0; i < 24; i++) begin
            step(1'b1, i == 0, 3'b100, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL single_vend cycle %0d: outputs %b, required %b", i, obs, exp);
            end
            checks++;
            if (obs[5] !== (i >= 1 && i <= 4)) begin
                errors++;
                $display("FAIL single_soda cycle %0d: soda %b, required %b", i, obs[5], i >= 1 && i <= 4);
            end
            if (obs[4]) dime_cyc++;
            if (obs[3]) nick_cyc++;
            if (obs[1] && done_at < 0) done_at = i;
        end
        checks++;
        if (dime_cyc !== 8) begin
            errors++;
            $display("FAIL single_dimes: dime cycles %0d, required 8", dime_cyc);
        end
        checks++;
        if (nick_cyc !== 0) begin
            errors++;
            $display("FAIL single_nickels: nickel cycles %0d, required 0", nick_cyc);
        end
        checks++;
        if (done_at !== 19) begin
            errors++;
            $display("FAIL single_done: done at %0d, required 19", done_at);
        end
    endtask

    task automatic test_codes;
        logic [5:0] obs, exp;
        int dime_cyc = 0, nick_cyc = 0, first_dime = -1, first_nick = -1, done_at = -1;
        for (int i = 0; i < 22; i++) begin
            step(1'b1, i == 0, 3'b011, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL code15 cycle %0d: outputs %b, required %b", i, obs, exp);
            end
            if (obs[4]) begin dime_cyc++; if (first_dime < 0) first_dime = i; end
            if (obs[3]) begin nick_cyc++; if (first_nick < 0) first_nick = i; end
        end
        checks++;
        if (dime_cyc !== P || nick_cyc !== P || first_dime > first_nick) begin
            errors++;
            $display("FAIL code15_coins: dime %0d nickel %0d first %0d/%0d, required 4 4 dime first",
                     dime_cyc, nick_cyc, first_dime, first_nick);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, i == 0, 3'b000, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL code0 cycle %0d: outputs %b, required %b", i, obs, exp);
            end
            if (obs[1] && done_at < 0) done_at = i;
        end
        checks++;
        if (done_at !== 7) begin
            errors++;
            $display("FAIL code0_done: done at %0d, required 7", done_at);
        end
    endtask

    task automatic test_back_to_back;
        logic [5:0] obs, exp;
        int faults = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, i <= 2, 3'b000, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL b2b cycle %0d: outputs %b, required %b", i, obs, exp);
            end
            if (obs[0]) faults++;
            if (i == 7 || i == 8) begin
                checks++;
                if (obs[1] !== (i == 7) || obs[5] !== (i == 8)) begin
                    errors++;
                    $display("FAIL b2b_restart cycle %0d: done %b soda %b, required %b %b",
                             i, obs[1], obs[5], i == 7, i == 8);
                end
            end
        end
        checks++;
        if (faults !== 1) begin
            errors++;
            $display("FAIL b2b_faults: fault pulses %0d, required 1", faults);
        end
    endtask

    task automatic test_invalid;
        logic [5:0] obs, exp;
        int coin_cyc = 0, soda_cyc = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, i == 0, 3'b110, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL invalid cycle %0d: outputs %b, required %b", i, obs, exp);
            end
            checks++;
            if (obs[0] !== (i == 1)) begin
                errors++;
                $display("FAIL invalid_fault cycle %0d: fault %b, required %b", i, obs[0], i == 1);
            end
            if (obs[4] || obs[3]) coin_cyc++;
            if (obs[5]) soda_cyc++;
        end
        checks++;
        if (coin_cyc !== 0 || soda_cyc !== P) begin
            errors++;
            $display("FAIL invalid_dispense: coin cycles %0d soda cycles %0d, required 0 4",
                     coin_cyc, soda_cyc);
        end
    endtask

    task automatic test_reset_mid;
        logic [5:0] obs, exp;
        logic       ev;
        logic [2:0] code;
        int         nick_cyc = 0;
        for (int i = 0; i < 22; i++) begin
            ev   = (i == 0) || (i == 2) || (i == 12);
            code = (i == 2) ? 3'b011 : ((i == 0) ? 3'b100 : 3'b000);
            step(i != 8, ev, code, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_mid cycle %0d: outputs %b, required %b", i, obs, exp);
            end
            if (i == 8 || i == 9 || i == 13) begin
                checks++;
                if (obs !== ((i == 8) ? 6'b010100 : ((i == 9) ? 6'b000000 : 6'b100100))) begin
                    errors++;
                    $display("FAIL reset_mid_point cycle %0d: outputs %b", i, obs);
                end
            end
            if (obs[3]) nick_cyc++;
        end
        checks++;
        if (nick_cyc !== 0) begin
            errors++;
            $display("FAIL reset_mid_pending: nickel cycles %0d, required 0", nick_cyc);
        end
    endtask

    task automatic test_random;
        logic [5:0] obs, exp;
        logic       rst, ev;
        logic [2:0] code;
        for (int i = 0; i < 700; i++) begin
            rst  = (i >= 660) || ($urandom_range(0, 99) != 0);
            ev   = (i < 660) && ($urandom_range(0, 5) == 0);
            code = 3'($urandom_range(0, 7));
            step(rst, ev, code, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random cycle %0d: outputs %b, required %b", i, obs, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_vend();
        test_codes();
        test_back_to_back();
        test_invalid();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
